// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2,
        ST_ADV   = 2'd3
    } arb_state_t;

    localparam int          DEF_AW       = 32;
    localparam int          DEF_DW       = 32;
    localparam int          DEF_TIMEOUT  = 16;
    localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled as one bus.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic          bus_err;
    logic [31:0]   stall_cnt;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_rdata, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               stall, bus_err, stall_cnt
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_rdata, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               stall, bus_err, stall_cnt
    );
endinterface

// File: rtl/mem_arb_wdog.sv
// Access watchdog: counts request cycles and pulses timeout_o on the TIMEOUT-th one.
module mem_arb_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // cnt_q holds completed wait cycles, so this fires during the TIMEOUT-th one.
    assign timeout_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: per pipeline cycle runs data access, then fetch,
// then one ADV cycle with stall low so the pipeline picks up the held results.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            AW       = DEF_AW,
    parameter int            DW       = DEF_DW,
    parameter int            TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DW-1:0] NOP_WORD = DW'(DEF_NOP_WORD)
) (
    input  logic       CLK,
    input  logic       RST,
    mem_arb_if.master  bus
);
    arb_state_t    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          pend_if_q, pend_if_d;
    logic          bus_err_q, bus_err_d;
    logic [31:0]   stall_cnt_q, stall_cnt_d;
    logic          stall, timeout, done;
    logic [DW-1:0] rd_word;

    mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (bus.mem_ack | ~mem_req_q),
        .en_i      (mem_req_q),
        .timeout_o (timeout)
    );

    // An ack in the timeout cycle takes precedence over the abort.
    assign done    = mem_req_q & (bus.mem_ack | timeout);
    assign rd_word = bus.mem_ack ? bus.mem_rdata : NOP_WORD;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        pend_if_d   = pend_if_q;
        bus_err_d   = bus_err_q;
        stall       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall = bus.dm_req | bus.if_req;
                if (bus.dm_req) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    pend_if_d   = bus.if_req;
                end else if (bus.if_req) begin
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    pend_if_d  = 1'b0;
                end
            end
            ST_DATA: begin
                stall = 1'b1;
                if (done) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q)    dm_rdata_d = rd_word;
                    if (!bus.mem_ack) bus_err_d  = 1'b1;
                    if (pend_if_q) begin
                        // Fetch request is raised one cycle later, leaving a gap.
                        state_d    = ST_FETCH;
                        mem_addr_d = bus.if_addr;
                        pend_if_d  = 1'b0;
                    end else begin
                        state_d = ST_ADV;
                    end
                end
            end
            ST_FETCH: begin
                stall = 1'b1;
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                end else if (done) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = rd_word;
                    if (!bus.mem_ack) bus_err_d = 1'b1;
                    state_d = ST_ADV;
                end
            end
            ST_ADV:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall_cnt_d = stall_cnt_q + 32'((stall && !(&stall_cnt_q)) ? 1 : 0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            pend_if_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            pend_if_q   <= pend_if_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall     = stall;
    assign bus.bus_err   = bus_err_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4 and a hand-driven memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(4), .NOP_WORD(32'h0000_0000)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_vec     = 0;
    int n_err     = 0;
    int obs_stall = 0;

    always @(negedge clk) begin
        if (!rst_n)              obs_stall <= 0;
        else if (bus.stall === 1'b1) obs_stall <= obs_stall + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the rising edge; inputs are driven there.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // reset state
        repeat (2) cyc();
        #1;
        chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
        chk("rst_stall",    32'(bus.stall),   32'd0);
        chk("rst_bus_err",  32'(bus.bus_err), 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt,   32'd0);
        chk("rst_if_rdata", bus.if_rdata,     32'd0);
        chk("rst_mem_addr", bus.mem_addr,     32'd0);
        rst_n = 1'b1;

        // no requests: idle, no stall
        cyc(); #1;
        chk("idle_stall",   32'(bus.stall),   32'd0);
        chk("idle_mem_req", 32'(bus.mem_req), 32'd0);

        // fetch only, ack in second request cycle
        cyc();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040; #1;
        chk("f_idle_stall", 32'(bus.stall), 32'd1);
        cyc(); #1;
        chk("f_mem_req",  32'(bus.mem_req), 32'd1);
        chk("f_mem_addr", bus.mem_addr,     32'h0000_0040);
        chk("f_mem_we",   32'(bus.mem_we),  32'd0);
        chk("f_stall1",   32'(bus.stall),   32'd1);
        cyc();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2008_0005; #1;
        chk("f_stall2", 32'(bus.stall), 32'd1);
        cyc();
        bus.mem_ack = 1'b0; #1;
        chk("f_adv_stall",  32'(bus.stall),   32'd0);
        chk("f_adv_memreq", 32'(bus.mem_req), 32'd0);
        chk("f_if_rdata",   bus.if_rdata,     32'h2008_0005);
        chk("f_stall_cnt",  bus.stall_cnt,    32'd3);
        bus.if_req = 1'b0;
        cyc(); #1;
        chk("f_back_idle", 32'(bus.stall), 32'd0);

        // load + fetch, latency 1 each, with gap cycle between
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0010;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0044; #1;
        chk("lf_idle_stall", 32'(bus.stall), 32'd1);
        cyc(); #1;
        chk("lf_d_req",  32'(bus.mem_req), 32'd1);
        chk("lf_d_addr", bus.mem_addr,     32'h0000_0010);
        chk("lf_d_we",   32'(bus.mem_we),  32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        cyc();
        bus.mem_ack = 1'b0; #1;
        chk("lf_gap_req",   32'(bus.mem_req), 32'd0);
        chk("lf_gap_stall", 32'(bus.stall),   32'd1);
        chk("lf_gap_addr",  bus.mem_addr,     32'h0000_0044);
        cyc(); #1;
        chk("lf_f_req",  32'(bus.mem_req), 32'd1);
        chk("lf_f_addr", bus.mem_addr,     32'h0000_0044);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8C02_0010;
        cyc();
        bus.mem_ack = 1'b0; #1;
        chk("lf_adv_stall", 32'(bus.stall), 32'd0);
        chk("lf_dm_rdata",  bus.dm_rdata,   32'hDEAD_BEEF);
        chk("lf_if_rdata",  bus.if_rdata,   32'h8C02_0010);
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        cyc();

        // store: mem_* held while waiting, dm_rdata untouched
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h0000_0020;
        bus.dm_wdata = 32'h1234_5678;
        cyc(); #1;
        chk("st_we",    32'(bus.mem_we), 32'd1);
        chk("st_addr",  bus.mem_addr,    32'h0000_0020);
        chk("st_wdata", bus.mem_wdata,   32'h1234_5678);
        bus.dm_addr = 32'hFFFF_FFFC; bus.dm_wdata = 32'h0;
        cyc(); #1;
        chk("st_hold_req",   32'(bus.mem_req), 32'd1);
        chk("st_hold_addr",  bus.mem_addr,     32'h0000_0020);
        chk("st_hold_wdata", bus.mem_wdata,    32'h1234_5678);
        chk("st_hold_we",    32'(bus.mem_we),  32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        cyc();
        bus.mem_ack = 1'b0; #1;
        chk("st_adv_stall", 32'(bus.stall),   32'd0);
        chk("st_adv_req",   32'(bus.mem_req), 32'd0);
        chk("st_dm_rdata",  bus.dm_rdata,     32'hDEAD_BEEF);
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        cyc();

        // timeout race: ack on the 4th request cycle wins
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0048;
        cyc();
        cyc();
        cyc();
        cyc();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D; #1;
        chk("race_req4", 32'(bus.mem_req), 32'd1);
        cyc();
        bus.mem_ack = 1'b0; #1;
        chk("race_bus_err",   32'(bus.bus_err), 32'd0);
        chk("race_if_rdata",  bus.if_rdata,     32'h0BAD_F00D);
        chk("race_adv_stall", 32'(bus.stall),   32'd0);
        chk("race_stall_cnt", bus.stall_cnt,    32'(obs_stall));
        bus.if_req = 1'b0;
        cyc();

        // timeout: no ack for 4 request cycles
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_004C;
        cyc();
        cyc();
        cyc();
        cyc(); #1;
        chk("to_req4",     32'(bus.mem_req), 32'd1);
        chk("to_err_pre",  32'(bus.bus_err), 32'd0);
        cyc(); #1;
        chk("to_req_drop", 32'(bus.mem_req), 32'd0);
        chk("to_bus_err",  32'(bus.bus_err), 32'd1);
        chk("to_if_rdata", bus.if_rdata,     32'h0000_0000);
        chk("to_adv",      32'(bus.stall),   32'd0);
        bus.if_req = 1'b0;
        cyc(); #1;
        chk("to_err_sticky", 32'(bus.bus_err), 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        cyc(); #1;
        chk("stray_ack_req",   32'(bus.mem_req), 32'd0);
        chk("stray_ack_stall", 32'(bus.stall),   32'd0);
        chk("stray_ack_err",   32'(bus.bus_err), 32'd1);
        bus.mem_ack = 1'b0;

        // reset in the middle of a data access
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0030;
        cyc(); #1;
        chk("mr_req", 32'(bus.mem_req), 32'd1);
        #1;
        bus.dm_req = 1'b0; rst_n = 1'b0; #1;
        chk("mr_req_drop",  32'(bus.mem_req), 32'd0);
        chk("mr_stall",     32'(bus.stall),   32'd0);
        chk("mr_stall_cnt", bus.stall_cnt,    32'd0);
        chk("mr_if_rdata",  bus.if_rdata,     32'd0);
        chk("mr_bus_err",   32'(bus.bus_err), 32'd0);
        chk("mr_dm_rdata",  bus.dm_rdata,     32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        cyc();
        rst_n = 1'b1;
        cyc(); #1;
        chk("mr_late_ack_req",   32'(bus.mem_req), 32'd0);
        chk("mr_late_ack_stall", 32'(bus.stall),   32'd0);
        chk("mr_late_ack_dm",    bus.dm_rdata,     32'd0);
        bus.mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the IF stage (instruction fetch at PCF) and the MEM stage (load/store at ALUOutM / WriteDataM).
- Sequences each pipeline cycle: data access first, then fetch, then one ADVANCE cycle with both results held stable.
- Holds the whole pipeline frozen via a single stall output until the current pipeline cycle's accesses complete.
- Sits between the pipelined datapath/hazard unit and the external memory model; replaces the separate IM/DM ports.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, max cycles mem_req may wait for mem_ack before abort (≥2).
- NOP_WORD, 32'h0000_0000, data returned on an aborted access.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch needed this pipeline cycle.
- if_addr  in  AW  fetch address (PCF).
- if_rdata  out  DW  fetched instruction (IM_RD).
- dm_req  in  1  MEM stage has a load or store.
- dm_we  in  1  1 = store.
- dm_addr  in  AW  data address (ALUOutM).
- dm_wdata  in  DW  store data (WriteDataM).
- dm_rdata  out  DW  load data (DM_RD).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  AW  registered.
- mem_wdata  out  DW  registered.
- mem_ack  in  1  memory completion; earliest one cycle after mem_req rises.
- mem_rdata  in  DW  valid only when mem_ack=1.
- stall  out  1  1 = hold PC and all pipeline registers.
- bus_err  out  1  sticky timeout flag.
- stall_cnt  out  32  saturating count of cycles with stall=1.

Behaviour:
- States: IDLE, DATA, FETCH, ADV. Encoding lives in the package.
- Reset (RST=0, async): state=IDLE. mem_req, mem_we, bus_err=0. mem_addr, mem_wdata, if_rdata, dm_rdata=0. stall_cnt=0. Watchdog=0. Reset mid-access drops mem_req immediately; the late mem_ack is ignored.
- IDLE:
  - Samples requests. dm_req=1 -> DATA, latching dm_we/dm_addr/dm_wdata into mem_* and pend_if<=if_req.
  - Else if_req=1 -> FETCH, latching if_addr, mem_we=0.
  - Else stay IDLE.
  - stall = dm_req|if_req in IDLE.
- DATA/FETCH:
  - mem_req=1; mem_* stable until the ack cycle inclusive; stall=1.
  - Inputs are ignored because the pipeline is frozen.
  - Ack in DATA: loads capture mem_rdata -> dm_rdata; stores leave dm_rdata unchanged. Next state is FETCH (latch if_addr) if pend_if, else ADV. mem_req drops for at least one cycle between accesses.
  - Ack in FETCH: mem_rdata -> if_rdata; next state ADV.
- ADV: stall=0 for exactly one cycle, so pipeline registers load held if_rdata/dm_rdata; next state IDLE.
- Priority: data over fetch whenever both are requested (older instruction first).
- Minimum latency, fetch only: IDLE(stall) -> FETCH (≥1 cycle) -> ADV, i.e. 3 cycles per instruction.
- No requests: stall=0 in IDLE; no state change.
- Watchdog:
  - Counts cycles with mem_req=1, clears on ack or state exit.
  - At count==TIMEOUT with no ack: abort, bus_err<=1 (sticky until reset), and load NOP_WORD into the target read register (stores: no write-back).
  - Then advance as if acked; mem_req drops.
  - An ack arriving in the same cycle as the timeout wins (no error).
- stall_cnt: +1 each cycle stall=1; saturates at 32'hFFFF_FFFF.
- Hazard-unit stalls and branch flushes in the ADV cycle need no special handling; the next pipeline cycle re-fetches the unchanged PC.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, DATA, FETCH, ADV).
  - NOP_WORD constant.
  - Default AW/DW/TIMEOUT.
- Sub-module mem_arb_wdog: counter with clr/en inputs and a timeout pulse; width is $clog2(TIMEOUT+1).
- Everything else stays in one FSM module.

Test Plan:
- Reset: RST=0 mid-DATA with mem_req=1 -> mem_req=0 immediately, stall=0, state IDLE, stall_cnt=0, if_rdata=0.
- Fetch only: if_req=1, if_addr=0x0000_0040, ack after 2 cycles with 0x2008_0005 -> mem_addr=0x40, mem_we=0; stall=1 for 3 cycles then 0 for 1 cycle; if_rdata=0x2008_0005.
- Load+fetch: dm_req=1, dm_we=0, dm_addr=0x10, if_addr=0x44, both ack latency 1, data 0xDEAD_BEEF then 0x8C02_0010 -> data access first, gap cycle, then fetch; ADV shows dm_rdata=0xDEAD_BEEF, if_rdata=0x8C02_0010.
- Store: dm_we=1, dm_addr=0x20, dm_wdata=0x1234_5678 -> mem_we=1 with stable mem_addr/mem_wdata until ack; dm_rdata unchanged.
- Timeout: TIMEOUT=4, no ack on fetch -> abort after 4 mem_req cycles, bus_err=1 (stays 1), if_rdata=0x0000_0000, then ADV.
- Timeout race: ack on exactly the 4th cycle -> no error, data captured; stall_cnt equals the number of stall=1 cycles observed.
